// File: rtl/cmd_proc.sv
// Command dispatcher: consumes UART command words, launches cal/heading/move, returns a status byte.
// Optional watchdog on the operation wait states is enabled by defining CMD_TIMEOUT_EN.
module cmd_proc #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        strt_hdng,
  output logic [11:0] dsrd_hdng,
  input  logic        hdng_done,
  output logic        strt_mv,
  output logic [7:0]  mv_frwrd,
  input  logic        mv_done,
  output logic        busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] WAIT_CAL  = 3'd2;
  localparam logic [2:0] WAIT_HDNG = 3'd3;
  localparam logic [2:0] WAIT_MV   = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;
  localparam logic [2:0] RESP_WAIT = 3'd6;

  localparam logic [3:0] OP_CAL  = 4'h0;
  localparam logic [3:0] OP_HDNG = 4'h2;
  localparam logic [3:0] OP_MV   = 4'h4;

  localparam logic [7:0] ST_ACK = 8'hA5;
  localparam logic [7:0] ST_NAK = 8'hEE;
  localparam logic [7:0] ST_TO  = 8'hE0;

  logic [2:0]  state, nxt_state;
  logic [15:0] cmd_q;
  logic        run;
  logic        resp_ld;
  logic [7:0]  resp_nxt;
  logic        wait_st;
  logic        done_hit;
  logic        to_hit;

  assign wait_st  = (state == WAIT_CAL) || (state == WAIT_HDNG) || (state == WAIT_MV);
  assign done_hit = ((state == WAIT_CAL)  && cal_done)  ||
                    ((state == WAIT_HDNG) && hdng_done) ||
                    ((state == WAIT_MV)   && mv_done);

`ifdef CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt;

  // Held at zero outside the wait states, so every WAIT_x starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (!wait_st)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = wait_st && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    nxt_state   = state;
    resp_ld     = 1'b0;
    resp_nxt    = resp;
    clr_cmd_rdy = 1'b0;
    strt_cal    = 1'b0;
    strt_hdng   = 1'b0;
    strt_mv     = 1'b0;
    case (state)
      IDLE: begin
        // run keeps the receiver untouched for the first cycle after reset release
        if (cmd_rdy && run) begin
          clr_cmd_rdy = 1'b1;
          nxt_state   = DECODE;
        end
      end
      DECODE: begin
        case (cmd_q[15:12])
          OP_CAL:  begin strt_cal  = 1'b1; nxt_state = WAIT_CAL;  end
          OP_HDNG: begin strt_hdng = 1'b1; nxt_state = WAIT_HDNG; end
          OP_MV:   begin strt_mv   = 1'b1; nxt_state = WAIT_MV;   end
          default: begin
            resp_ld   = 1'b1;
            resp_nxt  = ST_NAK;
            nxt_state = RESP;
          end
        endcase
      end
      WAIT_CAL, WAIT_HDNG, WAIT_MV: begin
        // done has priority over a coincident timeout
        if (done_hit) begin
          resp_ld   = 1'b1;
          resp_nxt  = ST_ACK;
          nxt_state = RESP;
        end else if (to_hit) begin
          resp_ld   = 1'b1;
          resp_nxt  = ST_TO;
          nxt_state = RESP;
        end
      end
      RESP:      nxt_state = RESP_WAIT;
      RESP_WAIT: if (resp_sent) nxt_state = IDLE;
      default:   nxt_state = IDLE;
    endcase
  end

  assign send_resp = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= 1'b0;
      cmd_q     <= '0;
      resp      <= '0;
      dsrd_hdng <= '0;
      mv_frwrd  <= '0;
    end else begin
      state <= nxt_state;
      run   <= 1'b1;
      if (clr_cmd_rdy)
        cmd_q <= cmd;
      if (resp_ld)
        resp <= resp_nxt;
      if (strt_hdng)
        dsrd_hdng <= cmd_q[11:0];
      if (strt_mv)
        mv_frwrd <= cmd_q[7:0];
    end
  end

endmodule

// File: doc/cmd_proc.md
# cmd_proc

Command dispatcher downstream of the UART command receiver. Consumes each 16-bit command (`cmd`/`cmd_rdy`), releases the receiver via `clr_cmd_rdy`, and launches the matching datapath operation: calibrate, set heading or move. Waits for that operation's completion. Returns a one-byte status (`resp`/`send_resp`) to the UART transmitter and holds off further commands until `resp_sent`.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum cycles spent waiting for an operation's done signal (used only with `CMD_TIMEOUT_EN`).
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cmd`  in  16  command word from receiver; `[15:12]` opcode, `[11:0]` operand
- `cmd_rdy`  in  1  level, command word valid
- `clr_cmd_rdy`  out  1  one-cycle pulse, consumes the command
- `resp`  out  8  status byte to transmitter
- `send_resp`  out  1  one-cycle pulse, starts transmission of `resp`
- `resp_sent`  in  1  transmitter done (pulse or level, sampled only in RESP_WAIT)
- `strt_cal`  out  1  one-cycle pulse, start calibration
- `cal_done`  in  1  calibration complete
- `strt_hdng`  out  1  one-cycle pulse, start heading change
- `dsrd_hdng`  out  12  desired heading, registered
- `hdng_done`  in  1  heading reached
- `strt_mv`  out  1  one-cycle pulse, start move
- `mv_frwrd`  out  8  move distance, registered from `cmd[7:0]`
- `mv_done`  in  1  move complete
- `busy`  out  1  high in every state except IDLE

## Operation
- Opcodes:
  - `4'h0` CAL: no operand.
  - `4'h2` HDNG: operand → `dsrd_hdng`.
  - `4'h4` MOVE: `cmd[7:0]` → `mv_frwrd`.
  - Any other opcode is illegal.
- Status codes: `8'hA5` ACK, `8'hEE` NAK (illegal opcode), `8'hE0` timeout.
- States: IDLE, DECODE, WAIT_CAL, WAIT_HDNG, WAIT_MV, RESP, RESP_WAIT.
  - IDLE: when `cmd_rdy`=1, assert `clr_cmd_rdy` combinationally in the same cycle and latch `cmd` into an internal register at that edge; go to DECODE.
  - DECODE: decode the latched opcode.
    - CAL: pulse `strt_cal`, go to WAIT_CAL.
    - HDNG: load `dsrd_hdng` at this edge, pulse `strt_hdng`, go to WAIT_HDNG.
    - MOVE: load `mv_frwrd`, pulse `strt_mv`, go to WAIT_MV.
    - Illegal: load `resp`=`8'hEE`, go to RESP.
  - WAIT_x: stay until the matching done is 1, then load `resp`=`8'hA5` and go to RESP. Done inputs for other operations are ignored.
  - RESP: assert `send_resp` for exactly one cycle, go to RESP_WAIT.
  - RESP_WAIT: on `resp_sent`=1, go to IDLE.
- `resp` is a register, stable from RESP entry until the next load.
- `dsrd_hdng` and `mv_frwrd` hold their value until the next HDNG or MOVE command.
- `cmd_rdy` outside IDLE is ignored and not cleared. The pending command is taken on the first IDLE cycle.
- Done asserted in the same cycle the state is entered counts immediately.
- Reset mid-operation: all state returns to IDLE. No response is sent for the aborted command.

## Timing
- Reset values: `clr_cmd_rdy`=0, `send_resp`=0, `strt_*`=0, `resp`=`8'h00`, `dsrd_hdng`=0, `mv_frwrd`=0, `busy`=0.
- `cmd_rdy` high in cycle N (IDLE): `clr_cmd_rdy`=1 in cycle N, DECODE in N+1, `strt_x` high in N+1 only.
- Illegal opcode: RESP in N+2, so `send_resp` is high in N+2.
- Done high in cycle M (WAIT_x): `resp` valid and `send_resp` high in M+1.
- `resp_sent` high in cycle K (RESP_WAIT): IDLE in K+1. The earliest next `clr_cmd_rdy` is in K+1.
- Minimum command-to-command spacing: 5 cycles (legal opcode, all handshakes immediate).

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to any WAIT_x and increments each cycle while in WAIT_x.
  - When the count reaches `TIMEOUT_CYCLES-1` without done, the next state is RESP with `resp`=`8'hE0`.
  - Done and timeout in the same cycle: done wins, ACK is sent.
  - The counter width is `$clog2(TIMEOUT_CYCLES)`.
- Not defined: no counter is generated. WAIT_x waits indefinitely and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Reset with `cmd_rdy`=1 held → all outputs at reset values. First `clr_cmd_rdy` one cycle after `rst_n` rises.
- `cmd`=`16'h0000`, `cal_done` 20 cycles after `strt_cal` → one `strt_cal` pulse; `resp`=`8'hA5` and `send_resp` the cycle after `cal_done`.
- `cmd`=`16'h23FF` → `dsrd_hdng`=`12'h3FF` with `strt_hdng`. `mv_done` pulses during the wait are ignored. ACK after `hdng_done`.
- `cmd`=`16'h4012` → `mv_frwrd`=`8'h12`. Second `cmd_rdy` asserted mid-move is not cleared until the cycle after `resp_sent`.
- `cmd`=`16'h7ABC` → no `strt_*` pulse; `resp`=`8'hEE`, `send_resp` two cycles after `clr_cmd_rdy`.
- With `CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, CAL with no `cal_done` → `resp`=`8'hE0`. Done coincident with the last count → `8'hA5`.
